// File: rtl/ptr_block_reader.sv
// Photoelectric tape reader controller: spins up the reader on a start request,
// reads host frames at the character rate, and delivers them until a STOP code ends the block.
module ptr_block_reader #(
  parameter int SPINUP_MS = 100,
  parameter int FRAME_MS  = 4,
  parameter int STOP_MS   = 10,
  parameter int STARVE_MS = 1000
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       tick_ms,
  input  logic       PWR_AUTO_TAPE_START,
  input  logic       CMD_TAPE_START,
  input  logic       fr_valid,
  input  logic [4:0] fr_data,
  output logic       fr_ready,
  output logic       WAIT_FOR_TAPE,
  output logic       TAPE_MOTOR,
  output logic       ptr_strobe,
  output logic [4:0] ptr_frame,
  output logic       tape_err,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SPINUP  = 2'd1;
  localparam logic [1:0] S_READ    = 2'd2;
  localparam logic [1:0] S_RUNDOWN = 2'd3;

  localparam logic [15:0] SPINUP_LIM  = 16'(SPINUP_MS);
  localparam logic [15:0] STOP_LIM    = 16'(STOP_MS);
  localparam logic [15:0] FRAME_LAST  = 16'(FRAME_MS - 1);
  localparam logic [15:0] STARVE_LAST = 16'(STARVE_MS - 1);

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [15:0] ms_cnt;
  logic [15:0] slot_cnt;
  logic [15:0] starve_cnt;
  logic        entry;
  logic        pwr_q;

  logic start;
  logic tick_cnt;
  logic slot;
  logic accept;
  logic starve_hit;
  logic is_blank;
  logic is_stop;
  logic is_illegal;
  logic deliver;

  // Frame handshake: the host holds fr_valid with fr_data stable until it sees
  // fr_ready. A frame transfers only at a READ slot edge where fr_valid is high;
  // fr_ready pulses for one cycle just after that edge. fr_valid may drop any time.
  assign start      = (PWR_AUTO_TAPE_START & ~pwr_q) | CMD_TAPE_START;
  assign tick_cnt   = tick_ms & ~entry;
  assign slot       = (state == S_READ) && tick_cnt && (slot_cnt == FRAME_LAST);
  assign accept     = slot && fr_valid;
  assign starve_hit = (state == S_READ) && tick_cnt && !accept && (starve_cnt == STARVE_LAST);

  assign is_blank   = (fr_data == 5'h00);
  assign is_stop    = (fr_data == 5'h04);
  assign is_illegal = !fr_data[4] && (fr_data[3:0] >= 4'd6);
  assign deliver    = accept && !is_blank && !is_stop && !is_illegal;

  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_SPINUP;
      S_SPINUP:  if (ms_cnt >= SPINUP_LIM) state_nx = S_READ;
      S_READ:    if ((accept && (is_stop || is_illegal)) || starve_hit) state_nx = S_RUNDOWN;
      S_RUNDOWN: if (ms_cnt >= STOP_LIM) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state         <= S_IDLE;
      entry         <= 1'b0;
      pwr_q         <= 1'b0;
      ms_cnt        <= 16'd0;
      slot_cnt      <= 16'd0;
      starve_cnt    <= 16'd0;
      fr_ready      <= 1'b0;
      WAIT_FOR_TAPE <= 1'b0;
      TAPE_MOTOR    <= 1'b0;
      ptr_strobe    <= 1'b0;
      ptr_frame     <= 5'd0;
      tape_err      <= 1'b0;
    end else begin
      pwr_q      <= PWR_AUTO_TAPE_START;
      state      <= state_nx;
      fr_ready   <= accept;
      ptr_strobe <= deliver;
      if (deliver) ptr_frame <= fr_data;

      // Counters restart on every state change; a tick landing in the entry cycle is dropped.
      if (state_nx != state) begin
        entry      <= 1'b1;
        ms_cnt     <= 16'd0;
        slot_cnt   <= 16'd0;
        starve_cnt <= 16'd0;
      end else begin
        entry <= 1'b0;
        if (tick_cnt) begin
          ms_cnt     <= ms_cnt + 16'd1;
          slot_cnt   <= (slot_cnt == FRAME_LAST) ? 16'd0 : slot_cnt + 16'd1;
          starve_cnt <= accept ? 16'd0 : starve_cnt + 16'd1;
        end
      end

      if (state == S_IDLE && state_nx == S_SPINUP) begin
        TAPE_MOTOR <= 1'b1;
        tape_err   <= 1'b0;
      end
      if (state == S_SPINUP && state_nx == S_READ) WAIT_FOR_TAPE <= 1'b1;
      if (state == S_READ && state_nx == S_RUNDOWN) begin
        TAPE_MOTOR <= 1'b0;
        if (starve_hit || (accept && is_illegal)) tape_err <= 1'b1;
      end
      if (state == S_RUNDOWN && state_nx == S_IDLE) WAIT_FOR_TAPE <= 1'b0;
    end
  end

endmodule
